// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared definitions for the ALU decode/issue stage: opcode values,
//   one-hot alusignals bit positions, instruction field positions and the
//   NOP opcode range. Imported by alu_decoder and alu_issue_unit.
package alu_issue_pkg;

   localparam int OPC_W   = 4;
   localparam int NALU_OP = 12;

   // Opcodes
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_LD  = 4'd1;
   localparam logic [3:0] OP_ST  = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_MUL = 4'd4;
   localparam logic [3:0] OP_CMP = 4'd5;
   localparam logic [3:0] OP_MOV = 4'd6;
   localparam logic [3:0] OP_OR  = 4'd7;
   localparam logic [3:0] OP_AND = 4'd8;
   localparam logic [3:0] OP_NOT = 4'd9;
   localparam logic [3:0] OP_LSL = 4'd10;
   localparam logic [3:0] OP_LSR = 4'd11;

   // Opcodes from OP_NOP_MIN upward are NOPs
   localparam logic [3:0] OP_NOP_MIN = 4'd12;

   // alusignals bit indices
   localparam int ALU_ADD = 0;
   localparam int ALU_LD  = 1;
   localparam int ALU_ST  = 2;
   localparam int ALU_SUB = 3;
   localparam int ALU_MUL = 4;
   localparam int ALU_CMP = 5;
   localparam int ALU_MOV = 6;
   localparam int ALU_OR  = 7;
   localparam int ALU_AND = 8;
   localparam int ALU_NOT = 9;
   localparam int ALU_LSL = 10;
   localparam int ALU_LSR = 11;

   // Instruction field positions
   localparam int F_OPC_LSB = 12;
   localparam int F_RD_LSB  = 9;
   localparam int F_RS1_LSB = 6;
   localparam int F_ISIMM   = 5;
   localparam int F_IMM_LSB = 0;
   localparam int F_IMM_W   = 5;
   localparam int F_RS2_LSB = 0;

   function automatic logic is_nop(input logic [3:0] opc);
      return (opc >= OP_NOP_MIN);
   endfunction

endpackage

// File: rtl/alu_issue_unit_decoder.sv
// alu_decoder
//   Combinational opcode decoder for the issue stage.
//   opcode_i      : instruction opcode [15:12]
//   alusignals_o  : one-hot ALU operation (all zero for NOPs)
//   writes_rd_o   : instruction writes its rd on retire
//   is_mem_o      : ld or st (retires as a memory request)
//   is_st_o       : st
//   uses_rs2_o    : rs2 field is a source when the immediate bit is clear
module alu_decoder
   import alu_issue_pkg::*;
(
   input  logic [3:0]  opcode_i,
   output logic [11:0] alusignals_o,
   output logic        writes_rd_o,
   output logic        is_mem_o,
   output logic        is_st_o,
   output logic        uses_rs2_o
);

   always_comb begin
      alusignals_o = '0;
      writes_rd_o  = 1'b0;
      is_mem_o     = 1'b0;
      is_st_o      = 1'b0;
      uses_rs2_o   = ~is_nop(opcode_i);
      case (opcode_i)
         OP_ADD: begin alusignals_o[ALU_ADD] = 1'b1; writes_rd_o = 1'b1; end
         OP_LD:  begin alusignals_o[ALU_LD]  = 1'b1; is_mem_o = 1'b1; end
         OP_ST:  begin alusignals_o[ALU_ST]  = 1'b1; is_mem_o = 1'b1; is_st_o = 1'b1; end
         OP_SUB: begin alusignals_o[ALU_SUB] = 1'b1; writes_rd_o = 1'b1; end
         OP_MUL: begin alusignals_o[ALU_MUL] = 1'b1; writes_rd_o = 1'b1; end
         OP_CMP: begin alusignals_o[ALU_CMP] = 1'b1; end
         OP_MOV: begin alusignals_o[ALU_MOV] = 1'b1; writes_rd_o = 1'b1; end
         OP_OR:  begin alusignals_o[ALU_OR]  = 1'b1; writes_rd_o = 1'b1; end
         OP_AND: begin alusignals_o[ALU_AND] = 1'b1; writes_rd_o = 1'b1; end
         OP_NOT: begin alusignals_o[ALU_NOT] = 1'b1; writes_rd_o = 1'b1; end
         OP_LSL: begin alusignals_o[ALU_LSL] = 1'b1; writes_rd_o = 1'b1; end
         OP_LSR: begin alusignals_o[ALU_LSR] = 1'b1; writes_rd_o = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Decode/issue stage in front of the clocked alu. Three stages:
//   D (accept + register-file read), X (registered ALU inputs),
//   W (aluresult valid, retire as write-back or memory request).
//   Optional feature macro: ALU_ISSUE_FWD_EN enables a W->X bypass so a
//   consumer only stalls while its producer is in X.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr/instr_valid/ready    instruction handshake from fetch queue
//   rs1_addr/rs2_addr          register-file read addresses (from instr)
//   rs1_data/rs2_data          register-file read data
//   alusignals/op1/op2/immx/isimmediate   registered ALU inputs (X)
//   aluresult                  registered ALU result (W)
//   wb_en/wb_addr/wb_data      register write-back
//   mem_req/mem_we/mem_addr    ld/st request
module alu_issue_unit
   import alu_issue_pkg::*;
#(
   parameter  int NREGS = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [15:0]   instr,
   input  logic          instr_valid,
   output logic          instr_ready,
   output logic [AW-1:0] rs1_addr,
   output logic [AW-1:0] rs2_addr,
   input  logic [15:0]   rs1_data,
   input  logic [15:0]   rs2_data,
   output logic [11:0]   alusignals,
   output logic [15:0]   op1,
   output logic [15:0]   op2,
   output logic [4:0]    immx,
   output logic          isimmediate,
   input  logic [15:0]   aluresult,
   output logic          wb_en,
   output logic [AW-1:0] wb_addr,
   output logic [15:0]   wb_data,
   output logic          mem_req,
   output logic          mem_we,
   output logic [15:0]   mem_addr
);

   logic [3:0]    d_opc;
   logic [AW-1:0] d_rd;
   logic          d_isimm;
   logic [4:0]    d_imm;
   logic [11:0]   dec_alusig;
   logic          dec_wr, dec_mem, dec_st, dec_rs2;
   logic          d_reads_rs2, haz_x, haz_w, stall, accept;
   logic [15:0]   src1, src2;

   logic          ready_q;
   logic          x_vld_q, x_vld_d, x_wr_q, x_wr_d, x_mem_q, x_mem_d, x_st_q, x_st_d;
   logic [AW-1:0] x_rd_q, x_rd_d;
   logic [11:0]   alusig_q, alusig_d;
   logic [15:0]   op1_q, op1_d, op2_q, op2_d;
   logic [4:0]    immx_q, immx_d;
   logic          isimm_q, isimm_d;
   logic          w_vld_q, w_wr_q, w_mem_q, w_st_q;
   logic [AW-1:0] w_rd_q;

   // ---- D stage: field extract, decode, hazard check ----
   assign d_opc    = instr[F_OPC_LSB +: OPC_W];
   assign d_rd     = instr[F_RD_LSB +: AW];
   assign d_isimm  = instr[F_ISIMM];
   assign d_imm    = instr[F_IMM_LSB +: F_IMM_W];
   assign rs1_addr = instr[F_RS1_LSB +: AW];
   assign rs2_addr = instr[F_RS2_LSB +: AW];

   alu_decoder u_dec (
      .opcode_i     (d_opc),
      .alusignals_o (dec_alusig),
      .writes_rd_o  (dec_wr),
      .is_mem_o     (dec_mem),
      .is_st_o      (dec_st),
      .uses_rs2_o   (dec_rs2)
   );

   assign d_reads_rs2 = ~d_isimm & dec_rs2;

   // x_wr_q/w_wr_q are only set for valid writing instructions
   assign haz_x = x_vld_q & x_wr_q &
                  ((x_rd_q == rs1_addr) | (d_reads_rs2 & (x_rd_q == rs2_addr)));
   assign haz_w = w_vld_q & w_wr_q &
                  ((w_rd_q == rs1_addr) | (d_reads_rs2 & (w_rd_q == rs2_addr)));

`ifdef ALU_ISSUE_FWD_EN
   // Producer in W: its result is on aluresult this cycle, bypass it
   assign stall = instr_valid & haz_x;
   assign src1  = (w_vld_q & w_wr_q & (w_rd_q == rs1_addr)) ? aluresult : rs1_data;
   assign src2  = (w_vld_q & w_wr_q & (w_rd_q == rs2_addr)) ? aluresult : rs2_data;
`else
   // Register file is read-old on a same-cycle write, so W must also block
   assign stall = instr_valid & (haz_x | haz_w);
   assign src1  = rs1_data;
   assign src2  = rs2_data;
   logic unused_fwd;
   assign unused_fwd = haz_w & 1'b0;
`endif

   assign instr_ready = ready_q & ~stall;
   assign accept      = instr_valid & instr_ready;

   always_comb begin
      x_vld_d  = 1'b0;
      x_wr_d   = 1'b0;
      x_mem_d  = 1'b0;
      x_st_d   = 1'b0;
      x_rd_d   = '0;
      alusig_d = '0;
      op1_d    = '0;
      op2_d    = '0;
      immx_d   = '0;
      isimm_d  = 1'b0;
      if (accept) begin
         x_vld_d  = 1'b1;
         x_wr_d   = dec_wr;
         x_mem_d  = dec_mem;
         x_st_d   = dec_st;
         x_rd_d   = d_rd;
         alusig_d = dec_alusig;
         op1_d    = src1;
         op2_d    = src2;
         immx_d   = d_imm;
         isimm_d  = d_isimm;
      end
   end

   // ---- X and W stage registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q  <= 1'b0;
         x_vld_q  <= 1'b0;
         x_wr_q   <= 1'b0;
         x_mem_q  <= 1'b0;
         x_st_q   <= 1'b0;
         x_rd_q   <= '0;
         alusig_q <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         immx_q   <= '0;
         isimm_q  <= 1'b0;
         w_vld_q  <= 1'b0;
         w_wr_q   <= 1'b0;
         w_mem_q  <= 1'b0;
         w_st_q   <= 1'b0;
         w_rd_q   <= '0;
      end else begin
         ready_q  <= 1'b1;
         x_vld_q  <= x_vld_d;
         x_wr_q   <= x_wr_d;
         x_mem_q  <= x_mem_d;
         x_st_q   <= x_st_d;
         x_rd_q   <= x_rd_d;
         alusig_q <= alusig_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         immx_q   <= immx_d;
         isimm_q  <= isimm_d;
         w_vld_q  <= x_vld_q;
         w_wr_q   <= x_wr_q;
         w_mem_q  <= x_mem_q;
         w_st_q   <= x_st_q;
         w_rd_q   <= x_rd_q;
      end
   end

   assign alusignals  = alusig_q;
   assign op1         = op1_q;
   assign op2         = op2_q;
   assign immx        = immx_q;
   assign isimmediate = isimm_q;

   // ---- W stage: retire ----
   // Result buses are zero outside a retire so reset drives them to 0
   assign wb_en    = w_vld_q & w_wr_q;
   assign wb_addr  = w_rd_q;
   assign wb_data  = wb_en ? aluresult : 16'h0;
   assign mem_req  = w_vld_q & w_mem_q;
   assign mem_we   = mem_req & w_st_q;
   assign mem_addr = mem_req ? aluresult : 16'h0;

endmodule
